aud_sram_ctrl: RTL and testbench



---
 rtl/aud_sram_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_aud_sram_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_sram_ctrl.sv
// Memory-side responder for the audio DSP request handshake: serves one 16-bit
// sample per mem_start from/to an external 1M x 16 asynchronous SRAM.
module aud_sram_ctrl #(
    parameter int                ADDR_W   = 20,
    parameter int                ACC_CYC  = 2,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_mode,
    input  logic              i_mem_start,
    input  logic [2:0]        i_next_num,
    input  logic [15:0]       i_wdata,
    output logic              o_mem_fin,
    output logic [15:0]       o_rdata,
    output logic              o_play_end,
    output logic              o_rec_full,
    output logic [ADDR_W:0]   o_rec_len,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [15:0]       io_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam int             CNT_W    = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               mode_reg, mode_next;
    logic [2:0]         step_reg, step_next;
    logic [15:0]        wdata_reg, wdata_next;
    logic [ADDR_W:0]    rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]    wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]    rec_len_reg, rec_len_next;
    logic               rec_full_reg, rec_full_next;
    logic [15:0]        rdata_reg, rdata_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic               we_n_reg, we_n_next;
    logic               ce_n_reg, ce_n_next;
    logic               oe_n_reg, oe_n_next;
    logic               dq_oe_reg, dq_oe_next;
    logic               run_reg;
    logic               at_end;
    logic [ADDR_W:0]    rd_sum;

    assign at_end = (rd_ptr_reg >= rec_len_reg);
    assign rd_sum = rd_ptr_reg + {{(ADDR_W-2){1'b0}}, step_reg} + PTR_ONE;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        mode_next     = mode_reg;
        step_next     = step_reg;
        wdata_next    = wdata_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        rec_len_next  = rec_len_reg;
        rec_full_next = rec_full_reg;
        rdata_next    = rdata_reg;

        if (i_clear) begin
            state_next    = S_IDLE;
            rd_ptr_next   = '0;
            wr_ptr_next   = '0;
            rec_len_next  = '0;
            rec_full_next = 1'b0;
            rdata_next    = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_mem_start) begin
                        mode_next  = i_mode;
                        step_next  = i_next_num;
                        wdata_next = i_wdata;
                        if (!i_mode && at_end) begin
                            state_next = S_DONE;
                            rdata_next = '0;
                        end else if (i_mode && rec_full_reg) begin
                            state_next = S_DONE;
                        end else begin
                            state_next = S_ACC;
                            cnt_next   = CNT_LOAD;
                        end
                    end
                end
                S_ACC: begin
                    if (cnt_reg == '0) begin
                        state_next = S_DONE;
                        if (mode_reg) begin
                            wr_ptr_next  = wr_ptr_reg + PTR_ONE;
                            rec_len_next = wr_ptr_reg + PTR_ONE;
                            if (wr_ptr_reg[ADDR_W-1:0] == MAX_ADDR)
                                rec_full_next = 1'b1;
                        end else begin
                            rdata_next  = io_SRAM_DQ;
                            // fast-forward never runs past the recorded data
                            rd_ptr_next = (rd_sum >= rec_len_reg) ? rec_len_reg : rd_sum;
                        end
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Strobes are computed from the next state so they change only on clock edges.
    always_comb begin
        ce_n_next  = 1'b1;
        we_n_next  = 1'b1;
        oe_n_next  = 1'b1;
        dq_oe_next = 1'b0;
        addr_next  = addr_reg;
        if (state_next == S_ACC) begin
            ce_n_next  = 1'b0;
            we_n_next  = ~mode_next;
            oe_n_next  = mode_next;
            dq_oe_next = mode_next;
            addr_next  = mode_next ? wr_ptr_next[ADDR_W-1:0] : rd_ptr_next[ADDR_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            mode_reg     <= 1'b0;
            step_reg     <= '0;
            wdata_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            rec_len_reg  <= '0;
            rec_full_reg <= 1'b0;
            rdata_reg    <= '0;
            addr_reg     <= '0;
            we_n_reg     <= 1'b1;
            ce_n_reg     <= 1'b1;
            oe_n_reg     <= 1'b1;
            dq_oe_reg    <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            mode_reg     <= mode_next;
            step_reg     <= step_next;
            wdata_reg    <= wdata_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            rec_len_reg  <= rec_len_next;
            rec_full_reg <= rec_full_next;
            rdata_reg    <= rdata_next;
            addr_reg     <= addr_next;
            we_n_reg     <= we_n_next;
            ce_n_reg     <= ce_n_next;
            oe_n_reg     <= oe_n_next;
            dq_oe_reg    <= dq_oe_next;
            run_reg      <= 1'b1;
        end
    end

    // play_end reads 0 while in reset, then tracks rd_ptr >= rec_len.
    assign o_play_end  = run_reg & at_end;
    assign o_mem_fin   = (state_reg == S_DONE);
    assign o_rdata     = rdata_reg;
    assign o_rec_full  = rec_full_reg;
    assign o_rec_len   = rec_len_reg;
    assign o_SRAM_ADDR = addr_reg;
    assign o_SRAM_WE_N = we_n_reg;
    assign o_SRAM_CE_N = ce_n_reg;
    assign o_SRAM_OE_N = oe_n_reg;
    assign o_SRAM_LB_N = 1'b0;
    assign o_SRAM_UB_N = 1'b0;
    assign io_SRAM_DQ  = dq_oe_reg ? wdata_reg : 16'hzzzz;

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// Bench for aud_sram_ctrl: two instances (full-size and MAX_ADDR=3), each with an
// SRAM model, checked against a queue-based model of recorded audio.
module tb_aud_sram_ctrl;

    localparam int ACC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, mode, mem_start, sel;
    logic [2:0]  next_num;
    logic [15:0] wdata;

    wire [1:0]       fin_w, play_end_w, rec_full_w, we_w, ce_w, oe_w, lb_w, ub_w;
    wire [1:0][15:0] rdata_w;
    wire [1:0][20:0] rec_len_w;
    wire [1:0][19:0] addr_w;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        wire [15:0]  dq;
        logic [15:0] mem [0:1023];
        logic        start;
        assign start = mem_start && (int'(sel) == gi);

        aud_sram_ctrl #(
            .ADDR_W  (20),
            .ACC_CYC (ACC),
            .MAX_ADDR((gi == 0) ? 20'hFFFFF : 20'h00003)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_clear    (clear),
            .i_mode     (mode),
            .i_mem_start(start),
            .i_next_num (next_num),
            .i_wdata    (wdata),
            .o_mem_fin  (fin_w[gi]),
            .o_rdata    (rdata_w[gi]),
            .o_play_end (play_end_w[gi]),
            .o_rec_full (rec_full_w[gi]),
            .o_rec_len  (rec_len_w[gi]),
            .o_SRAM_ADDR(addr_w[gi]),
            .io_SRAM_DQ (dq),
            .o_SRAM_WE_N(we_w[gi]),
            .o_SRAM_CE_N(ce_w[gi]),
            .o_SRAM_OE_N(oe_w[gi]),
            .o_SRAM_LB_N(lb_w[gi]),
            .o_SRAM_UB_N(ub_w[gi])
        );

        assign dq = (!ce_w[gi] && !oe_w[gi] && we_w[gi]) ? mem[addr_w[gi][9:0]] : 16'hzzzz;
        always @(posedge clk) if (!ce_w[gi] && !we_w[gi]) mem[addr_w[gi][9:0]] <= dq;
    end

    wire        fin      = fin_w[sel];
    wire [15:0] rdata    = rdata_w[sel];
    wire        play_end = play_end_w[sel];
    wire        rec_full = rec_full_w[sel];
    wire [20:0] rec_len  = rec_len_w[sel];
    wire [19:0] addr     = addr_w[sel];
    wire        we_n     = we_w[sel];
    wire        ce_n     = ce_w[sel];
    wire        oe_n     = oe_w[sel];

    int fin_cnt = 0, we_cnt = 0, oe_cnt = 0;
    always @(negedge clk) begin
        if (fin)   fin_cnt++;
        if (!we_n) we_cnt++;
        if (!oe_n) oe_cnt++;
    end

    // reference model: recorded samples in order, play pointer, full flag
    logic [15:0] ref_mem[$];
    int          ref_rd = 0;
    bit          ref_full = 0;
    logic [15:0] ref_rdata = '0;
    int          ref_max = 20'hFFFFF;

    int n_checks = 0, n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic m, input logic [2:0] nn, input logic [15:0] wd);
        int lat, exp_lat, exp_addr, fin0, we0, oe0, len, nxt;
        len = ref_mem.size();
        exp_lat = 0;
        exp_addr = 0;
        if (m) begin
            if (!ref_full) begin
                exp_lat = ACC;
                exp_addr = len;
                ref_mem.push_back(wd);
                if (len == ref_max) ref_full = 1;
            end
        end else if (ref_rd >= len) begin
            ref_rdata = '0;
        end else begin
            exp_lat = ACC;
            exp_addr = ref_rd;
            ref_rdata = ref_mem[ref_rd];
            nxt = ref_rd + int'(nn) + 1;
            ref_rd = (nxt > len) ? len : nxt;
        end
        fin0 = fin_cnt; we0 = we_cnt; oe0 = oe_cnt;
        mode = m; next_num = nn; wdata = wd; mem_start = 1'b1;
        @(posedge clk); #1;
        mem_start = 1'b0; mode = 1'($urandom); next_num = 3'($urandom); wdata = 16'($urandom);
        if (exp_lat > 0) begin
            check_val("addr", 32'(addr), exp_addr);
            check_val("strobes", {ce_n, we_n, oe_n}, {1'b0, !m, m});
        end
        lat = 0;
        while (!fin && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", lat, exp_lat);
        @(posedge clk); #1;
        check_val("fin_low", fin, 1'b0);
        check_val("fin_pulses", fin_cnt - fin0, 1);
        check_val("we_cycles", we_cnt - we0, m ? exp_lat : 0);
        check_val("oe_cycles", oe_cnt - oe0, m ? 0 : exp_lat);
        check_val("rdata", rdata, ref_rdata);
        check_val("rec_len", 32'(rec_len), ref_mem.size());
        check_val("play_end", play_end, ref_rd >= ref_mem.size());
        check_val("rec_full", rec_full, ref_full);
        $display("req dut=%0d mode=%0d nn=%0d wd=%h lat=%0d rdata=%h len=%0d", sel, m, nn, wd, lat, rdata, rec_len);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        ref_mem.delete();
        ref_rd = 0; ref_full = 0; ref_rdata = '0;
        check_val("clr_len", 32'(rec_len), 0);
        check_val("clr_play_end", play_end, 1'b1);
        check_val("clr_rdata", rdata, 0);
        check_val("clr_full", rec_full, 1'b0);
        $display("clear dut=%0d", sel);
    endtask

    initial begin
        int fin0, we0;
        rst_n = 1'b0; clear = 1'b0; mode = 1'b0; mem_start = 1'b0;
        next_num = '0; wdata = '0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_fin", fin, 1'b0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_play_end", play_end, 1'b0);
        check_val("rst_full", rec_full, 1'b0);
        check_val("rst_len", 32'(rec_len), 0);
        check_val("rst_addr", 32'(addr), 0);
        check_val("rst_strobes", {we_n, ce_n, oe_n, lb_w[0], ub_w[0]}, 5'b11100);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("empty_play_end", play_end, 1'b1);

        // record four samples, then play them back and one past the end
        do_req(1'b1, 3'd0, 16'h0011);
        do_req(1'b1, 3'd0, 16'h0022);
        do_req(1'b1, 3'd0, 16'h0033);
        do_req(1'b1, 3'd0, 16'h0044);
        check_val("len4", 32'(rec_len), 4);
        for (int i = 0; i < 4; i++) do_req(1'b0, 3'd0, 16'h0);
        check_val("last_play", rdata, 16'h0044);
        check_val("play_end4", play_end, 1'b1);
        do_req(1'b0, 3'd0, 16'h0);

        // ten samples, fast-forward by three
        do_clear();
        for (int i = 0; i < 10; i++) do_req(1'b1, 3'd0, 16'(i));
        for (int i = 0; i < 5; i++) do_req(1'b0, 3'd2, 16'h0);

        // second start during an access is ignored
        fin0 = fin_cnt; we0 = we_cnt;
        mode = 1'b1; wdata = 16'hBEEF; mem_start = 1'b1;
        @(posedge clk); #1;
        mem_start = 1'b0; wdata = 16'hDEAD;
        @(posedge clk); #1;
        mem_start = 1'b1;
        @(posedge clk); #1;
        mem_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ref_mem.push_back(16'hBEEF);
        check_val("dbl_fins", fin_cnt - fin0, 1);
        check_val("dbl_we", we_cnt - we0, ACC);
        check_val("dbl_len", 32'(rec_len), ref_mem.size());
        do_req(1'b0, 3'd0, 16'h0);
        check_val("dbl_data", rdata, 16'hBEEF);

        // clear on the second access cycle of a write aborts it
        fin0 = fin_cnt;
        mode = 1'b1; wdata = 16'h1234; mem_start = 1'b1;
        @(posedge clk); #1;
        mem_start = 1'b0;
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        ref_mem.delete(); ref_rd = 0; ref_full = 0; ref_rdata = '0;
        check_val("abort_we", we_n, 1'b1);
        check_val("abort_ce", ce_n, 1'b1);
        check_val("abort_len", 32'(rec_len), 0);
        check_val("abort_play_end", play_end, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_val("abort_fins", fin_cnt - fin0, 0);

        // small SRAM: fills after four samples
        sel = 1'b1; ref_max = 3;
        do_clear();
        for (int i = 0; i < 5; i++) do_req(1'b1, 3'd0, 16'($urandom));
        check_val("small_full", rec_full, 1'b1);
        check_val("small_len", 32'(rec_len), 4);

        // randomized mix on the full-size instance
        sel = 1'b0; ref_max = 20'hFFFFF;
        do_clear();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) do_clear();
            else if (ref_mem.size() >= 1000) do_req(1'b0, 3'($urandom), 16'h0);
            else do_req(1'($urandom), 3'($urandom), 16'($urandom));
        end

        // asynchronous reset in the middle of a write
        mode = 1'b1; wdata = 16'h5A5A; mem_start = 1'b1;
        @(posedge clk); #1;
        mem_start = 1'b0;
        check_val("ar_we_active", we_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_we", we_n, 1'b1);
        check_val("ar_ce", ce_n, 1'b1);
        check_val("ar_len", 32'(rec_len), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("ar_fin", fin, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
